i2c_wr_arbiter: RTL and testbench
=================================

# i2c_wr_arbiter

Round-robin arbiter and sequencer that shares one I2C write master between `N_REQ` requesters. Each requester offers a 7-bit slave id and one data byte. The block grants one requester at a time and launches the master with a single-cycle start pulse. It then waits for the master's completion pulse, or aborts on timeout, and enforces a bus-free gap before the next grant. It sits between the firmware- or FSM-side requesters and the I2C master that drives `scl`/`sda`.

## Interface
Parameters:
- `N_REQ`, default 4: number of requesters, range 2..8.
- `TIMEOUT`, default 1024: maximum WAIT cycles before abort, at least 2.
- `GAP`, default 4: idle cycles after each transaction, at least 1.

Ports:
- `clk`  in  1: single clock; all logic on the rising edge.
- `rst_n`  in  1: reset, asynchronous and active-low.
- `req_valid`  in  N_REQ: request pending, one bit per requester.
- `req_id`  in  7*N_REQ: slave id; requester k uses bits [7k+6:7k].
- `req_data`  in  8*N_REQ: data byte; requester k uses bits [8k+7:8k].
- `req_ready`  out  N_REQ: one-hot, one-cycle accept pulse.
- `req_done`  out  N_REQ: one-hot, one-cycle completion pulse.
- `req_err`  out  1: qualifies `req_done`; 1 means timeout.
- `m_valid`  out  1: one-cycle start pulse to the master.
- `m_id`  out  7: id to the master; held from ISSUE until the next grant.
- `m_data`  out  8: byte to the master; held the same way as `m_id`.
- `m_done`  in  1: master completion pulse (stop condition sent).
- `busy`  out  1: high when the state is not IDLE.
- `grant_idx`  out  clog2(N_REQ): index of the current or last grantee.

## Operation
- States are IDLE, ISSUE, WAIT and GAP.
- **IDLE**
  - When `req_valid` is nonzero, select the winner by round-robin, searching from `last+1` upward and wrapping modulo `N_REQ`.
  - On that edge: latch the winner's id/data into `m_id`/`m_data`, set `grant_idx` and `last` to the winner, and go to ISSUE.
  - When `req_valid` is zero, stay in IDLE.
- **ISSUE** lasts exactly one cycle:
  - `m_valid`=1 and `req_ready[grant_idx]`=1.
  - Clear the WAIT counter and go to WAIT.
- **WAIT**
  - The counter increments every cycle.
  - If `m_done`=1: go to GAP with `req_err`=0.
  - Else, if counter==TIMEOUT-1: go to GAP with `req_err`=1.
  - `m_done` and timeout in the same cycle counts as success (err=0).
- **GAP**
  - During the first GAP cycle: `req_done[grant_idx]`=1 and `req_err` is valid.
  - `req_err` is 0 whenever no `req_done` bit is set.
  - GAP lasts exactly `GAP` cycles, then returns to IDLE.
- **Requester contract**
  - Hold `req_valid`, `req_id` and `req_data` stable until `req_ready` is seen.
  - Deassert or change the request in the cycle after `req_ready`.
  - A requester still asserting `req_valid` after its done pulse is re-arbitrated normally.
- `m_done` is ignored in IDLE, ISSUE and GAP.
- Requests that drop before they are granted are simply not granted; nothing is latched.

## Timing
- Reset values:
  - all outputs 0 (`req_ready`, `req_done`, `req_err`, `m_valid`, `m_id`, `m_data`, `busy`, `grant_idx`);
  - state IDLE;
  - counters 0;
  - `last`=N_REQ-1, so requester 0 has first priority after reset.
- Latency:
  - `req_valid` sampled in IDLE at cycle T gives `m_valid`/`req_ready` in T+1.
  - `m_done` at cycle W gives `req_done` in W+1.
  - Next earliest `m_valid` is at W+1+GAP+1.
- Timeout: WAIT lasts at most `TIMEOUT` cycles, so the `req_done` error pulse comes no later than ISSUE+TIMEOUT+1.
- All outputs are registered; no combinational path from inputs to outputs.
- Reset asserted mid-transaction:
  - outputs return to reset values immediately (asynchronously);
  - no `req_done` is issued for the aborted transaction;
  - the round-robin pointer is reset.
- The `m_id`/`m_data` width is fixed (7/8). There is no arithmetic on the payload.

## Test plan
- **Single request.** From reset, `req_valid`=4'b0010, id 0x50, data 0xA5 at cycle 0.
  - Cycle 1: `m_valid`=1, `req_ready`=4'b0010, `m_id`=0x50, `m_data`=0xA5, `grant_idx`=1.
  - `m_done` at cycle 31 -> `req_done`=4'b0010 with `req_err`=0 at cycle 32.
  - `busy` falls at cycle 36.
- **Fairness.** All four requesters held valid continuously, `m_done` 10 cycles after each `m_valid`.
  - Grant order is 0,1,2,3,0,1.
  - Consecutive `m_valid` pulses are exactly 16 cycles apart (ISSUE 1 + WAIT 10 + GAP 4 + IDLE 1).
- **Timeout.** TIMEOUT=16, one request, `m_done` never asserted -> `req_done` with `req_err`=1 exactly 17 cycles after `m_valid`.
- **Simultaneous done and timeout.** `m_done` asserted in the 16th WAIT cycle (counter=15) -> `req_err`=0.
- **Stray done.** `m_done` pulsed in IDLE and during GAP -> no `req_done`, no state change.
- **Reset mid-WAIT.** Assert `rst_n`=0 for 2 cycles during WAIT.
  - All outputs are 0 at once.
  - After release, with requests 4'b1111, the first grant is requester 0.
  - No `req_done` is issued for the aborted transaction.

Source files
------------

// File: rtl/i2c_wr_arbiter.sv
// i2c_wr_arbiter: round-robin arbiter and sequencer sharing one I2C write
// master between N_REQ requesters. A grant launches the master with a
// one-cycle start pulse. The block then waits for completion or times out,
// and holds the bus idle for GAP cycles before the next grant.
module i2c_wr_arbiter #(
  parameter int N_REQ   = 4,
  parameter int TIMEOUT = 1024,
  parameter int GAP     = 4
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic [N_REQ-1:0]         req_valid,
  input  logic [7*N_REQ-1:0]       req_id,
  input  logic [8*N_REQ-1:0]       req_data,
  output logic [N_REQ-1:0]         req_ready,
  output logic [N_REQ-1:0]         req_done,
  output logic                     req_err,
  output logic                     m_valid,
  output logic [6:0]               m_id,
  output logic [7:0]               m_data,
  input  logic                     m_done,
  output logic                     busy,
  output logic [$clog2(N_REQ)-1:0] grant_idx
);

  localparam int IDX_W   = $clog2(N_REQ);
  localparam int CNT_MAX = (TIMEOUT > GAP) ? TIMEOUT : GAP;
  localparam int CNT_W   = $clog2(CNT_MAX + 32'sd1);

  localparam logic [CNT_W-1:0] TO_LAST  = CNT_W'(TIMEOUT - 32'sd1);
  localparam logic [CNT_W-1:0] GAP_LAST = CNT_W'(GAP - 32'sd1);
  localparam logic [CNT_W-1:0] CNT_ONE  = {{(CNT_W-1){1'b0}}, 1'b1};
  localparam logic [N_REQ-1:0] HOT_0    = {{(N_REQ-1){1'b0}}, 1'b1};
  localparam logic [IDX_W-1:0] LAST_RST = IDX_W'(N_REQ - 32'sd1);

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ISSUE = 2'd1,
    ST_WAIT  = 2'd2,
    ST_GAP   = 2'd3
  } state_t;

  state_t             state_r, state_s;
  logic [CNT_W-1:0]   cnt_r, cnt_s;
  logic [IDX_W-1:0]   last_r, last_s;
  logic [IDX_W-1:0]   grant_s;
  logic [6:0]         m_id_s;
  logic [7:0]         m_data_s;
  logic               m_valid_s;
  logic [N_REQ-1:0]   req_ready_s;
  logic [N_REQ-1:0]   req_done_s;
  logic               req_err_s;
  logic               win_found_s;
  logic [IDX_W-1:0]   win_idx_s;

  // Round-robin search: first valid requester after last, wrapping around.
  always_comb begin
    win_found_s = 1'b0;
    win_idx_s   = '0;
    for (int i = 1; i <= N_REQ; i++) begin
      if (!win_found_s && req_valid[(int'(last_r) + i) % N_REQ]) begin
        win_found_s = 1'b1;
        win_idx_s   = IDX_W'((int'(last_r) + i) % N_REQ);
      end else begin
        win_found_s = win_found_s;
      end
    end
  end

  // Next-state and next-output logic; all outputs are registered below.
  always_comb begin
    state_s     = state_r;
    cnt_s       = cnt_r;
    last_s      = last_r;
    grant_s     = grant_idx;
    m_id_s      = m_id;
    m_data_s    = m_data;
    m_valid_s   = 1'b0;
    req_ready_s = '0;
    req_done_s  = '0;
    req_err_s   = 1'b0;
    case (state_r)
      ST_IDLE: begin
        if (win_found_s) begin
          grant_s     = win_idx_s;
          last_s      = win_idx_s;
          m_id_s      = req_id[7*int'(win_idx_s) +: 7];
          m_data_s    = req_data[8*int'(win_idx_s) +: 8];
          m_valid_s   = 1'b1;
          req_ready_s = HOT_0 << win_idx_s;
          state_s     = ST_ISSUE;
        end else begin
          state_s = ST_IDLE;
        end
      end
      ST_ISSUE: begin
        cnt_s   = '0;
        state_s = ST_WAIT;
      end
      ST_WAIT: begin
        cnt_s = cnt_r + CNT_ONE;
        if (m_done) begin
          req_done_s = HOT_0 << grant_idx;
          req_err_s  = 1'b0;
          cnt_s      = '0;
          state_s    = ST_GAP;
        end else if (cnt_r == TO_LAST) begin
          req_done_s = HOT_0 << grant_idx;
          req_err_s  = 1'b1;
          cnt_s      = '0;
          state_s    = ST_GAP;
        end else begin
          state_s = ST_WAIT;
        end
      end
      ST_GAP: begin
        if (cnt_r == GAP_LAST) begin
          cnt_s   = '0;
          state_s = ST_IDLE;
        end else begin
          cnt_s   = cnt_r + CNT_ONE;
          state_s = ST_GAP;
        end
      end
      default: begin
        cnt_s   = '0;
        state_s = ST_IDLE;
      end
    endcase
  end

  // State, counters and registered outputs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r   <= ST_IDLE;
      cnt_r     <= '0;
      last_r    <= LAST_RST;
      grant_idx <= '0;
      m_id      <= 7'd0;
      m_data    <= 8'd0;
      m_valid   <= 1'b0;
      req_ready <= '0;
      req_done  <= '0;
      req_err   <= 1'b0;
      busy      <= 1'b0;
    end else begin
      state_r   <= state_s;
      cnt_r     <= cnt_s;
      last_r    <= last_s;
      grant_idx <= grant_s;
      m_id      <= m_id_s;
      m_data    <= m_data_s;
      m_valid   <= m_valid_s;
      req_ready <= req_ready_s;
      req_done  <= req_done_s;
      req_err   <= req_err_s;
      busy      <= (state_s != ST_IDLE);
    end
  end

endmodule

// File: tb/tb_i2c_wr_arbiter.sv
// Directed bench for i2c_wr_arbiter. Instance A uses the default TIMEOUT.
// Instance B uses TIMEOUT=16 for the timeout cases. Both share the stimulus.
module tb_i2c_wr_arbiter;

  logic        clk;
  logic        rst_n;
  logic [3:0]  req_valid;
  logic [27:0] req_id;
  logic [31:0] req_data;
  logic        m_done;

  logic [3:0] a_req_ready, a_req_done, b_req_ready, b_req_done;
  logic       a_req_err, a_m_valid, a_busy, b_req_err, b_m_valid, b_busy;
  logic [6:0] a_m_id, b_m_id;
  logic [7:0] a_m_data, b_m_data;
  logic [1:0] a_grant_idx, b_grant_idx;

  int total = 0;
  int bad   = 0;

  i2c_wr_arbiter #(.N_REQ(4), .TIMEOUT(1024), .GAP(4)) dut_a (
    .clk(clk), .rst_n(rst_n), .req_valid(req_valid), .req_id(req_id),
    .req_data(req_data), .req_ready(a_req_ready), .req_done(a_req_done),
    .req_err(a_req_err), .m_valid(a_m_valid), .m_id(a_m_id),
    .m_data(a_m_data), .m_done(m_done), .busy(a_busy),
    .grant_idx(a_grant_idx)
  );

  i2c_wr_arbiter #(.N_REQ(4), .TIMEOUT(16), .GAP(4)) dut_b (
    .clk(clk), .rst_n(rst_n), .req_valid(req_valid), .req_id(req_id),
    .req_data(req_data), .req_ready(b_req_ready), .req_done(b_req_done),
    .req_err(b_req_err), .m_valid(b_m_valid), .m_id(b_m_id),
    .m_data(b_m_data), .m_done(m_done), .busy(b_busy),
    .grant_idx(b_grant_idx)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic set_req(input int k, input logic [6:0] id, input logic [7:0] d);
    req_id[7*k +: 7]   = id;
    req_data[8*k +: 8] = d;
  endtask

  // Leaves the bench one cycle after release ("cycle 0").
  task automatic do_reset();
    rst_n     = 1'b0;
    req_valid = 4'b0000;
    m_done    = 1'b0;
    tick();
    tick();
    rst_n = 1'b1;
  endtask

  initial begin
    logic [3:0] exp_hot;
    logic [3:0] any_done;
    rst_n     = 1'b0;
    req_valid = 4'b0000;
    req_id    = 28'd0;
    req_data  = 32'd0;
    m_done    = 1'b0;
    tick();

    // Reset values
    chk("rst_a_ctl", {a_req_ready, a_req_done, a_req_err, a_m_valid, a_busy, a_grant_idx}, 32'd0);
    chk("rst_a_pay", {a_m_id, a_m_data}, 32'd0);
    chk("rst_b_ctl", {b_req_ready, b_req_done, b_req_err, b_m_valid, b_busy, b_grant_idx}, 32'd0);

    // Single request with stray done pulses in GAP and IDLE (instance A)
    do_reset();
    set_req(1, 7'h50, 8'hA5);
    req_valid = 4'b0010;
    tick(); // cycle 1
    chk("single_mvalid", a_m_valid, 32'd1);
    chk("single_ready", a_req_ready, 32'h2);
    chk("single_id", a_m_id, 32'h50);
    chk("single_data", a_m_data, 32'hA5);
    chk("single_grant", a_grant_idx, 32'd1);
    chk("single_busy1", a_busy, 32'd1);
    req_valid = 4'b0000;
    tick(); // cycle 2
    chk("single_pulse_end", {a_m_valid, a_req_ready}, 32'd0);
    repeat (29) tick(); // cycle 31
    m_done = 1'b1;
    chk("single_no_early_done", a_req_done, 32'd0);
    tick(); // cycle 32
    m_done = 1'b0;
    chk("single_done", a_req_done, 32'h2);
    chk("single_err", a_req_err, 32'd0);
    tick(); // cycle 33
    chk("single_done_pulse", a_req_done, 32'd0);
    m_done = 1'b1; // stray in GAP
    tick(); // cycle 34
    m_done = 1'b0;
    chk("stray_gap_done", a_req_done, 32'd0);
    chk("stray_gap_busy", a_busy, 32'd1);
    tick(); // cycle 35
    chk("single_busy35", a_busy, 32'd1);
    tick(); // cycle 36
    chk("single_busy36", a_busy, 32'd0);
    chk("single_id_held", a_m_id, 32'h50);
    m_done = 1'b1; // stray in IDLE
    tick(); // cycle 37
    m_done = 1'b0;
    chk("stray_idle", {a_busy, a_m_valid, a_req_done}, 32'd0);
    tick(); // cycle 38
    chk("stray_idle_busy", a_busy, 32'd0);

    // Fairness: all four valid, m_done 10 cycles after each m_valid
    do_reset();
    for (int k = 0; k < 4; k++) set_req(k, 7'h10 + 7'(k), 8'hC0 + 8'(k));
    req_valid = 4'b1111;
    tick(); // first m_valid
    for (int g = 0; g < 6; g++) begin
      exp_hot = 4'b0001 << (g % 4);
      chk("fair_mvalid", a_m_valid, 32'd1);
      chk("fair_grant", a_grant_idx, 32'(g % 4));
      chk("fair_ready", a_req_ready, 32'(exp_hot));
      chk("fair_id", a_m_id, 32'h10 + 32'(g % 4));
      chk("fair_data", a_m_data, 32'hC0 + 32'(g % 4));
      if (g == 5) req_valid = 4'b0000;
      repeat (10) tick();
      m_done = 1'b1;
      tick();
      m_done = 1'b0;
      chk("fair_done", a_req_done, 32'(exp_hot));
      chk("fair_err", a_req_err, 32'd0);
      repeat (4) tick();
      chk("fair_gap_no_mvalid", a_m_valid, 32'd0);
      tick();
    end
    chk("fair_end_idle", a_m_valid, 32'd0);

    // Timeout on instance B (TIMEOUT=16)
    do_reset();
    set_req(2, 7'h2A, 8'h3C);
    req_valid = 4'b0100;
    tick(); // cycle 1
    chk("to_mvalid", b_m_valid, 32'd1);
    chk("to_grant", b_grant_idx, 32'd2);
    req_valid = 4'b0000;
    repeat (16) tick(); // 16 after m_valid
    chk("to_not_yet", b_req_done, 32'd0);
    chk("to_busy", b_busy, 32'd1);
    tick(); // 17 after m_valid
    chk("to_done", b_req_done, 32'h4);
    chk("to_err", b_req_err, 32'd1);
    tick();
    chk("to_err_clear", {b_req_done, b_req_err}, 32'd0);
    repeat (3) tick(); // IDLE

    // Done on the last WAIT cycle counts as success
    set_req(0, 7'h11, 8'h22);
    req_valid = 4'b0001;
    tick();
    chk("sim_mvalid", b_m_valid, 32'd1);
    chk("sim_grant", b_grant_idx, 32'd0);
    req_valid = 4'b0000;
    repeat (16) tick(); // counter at TIMEOUT-1
    chk("sim_not_yet", b_req_done, 32'd0);
    m_done = 1'b1;
    tick();
    m_done = 1'b0;
    chk("sim_done", b_req_done, 32'h1);
    chk("sim_err", b_req_err, 32'd0);

    // Reset asserted mid-WAIT (instance A)
    do_reset();
    set_req(2, 7'h33, 8'h44);
    req_valid = 4'b0100;
    tick();
    chk("rw_grant", a_grant_idx, 32'd2);
    req_valid = 4'b0000;
    repeat (4) tick();
    chk("rw_busy", a_busy, 32'd1);
    rst_n = 1'b0;
    #1;
    chk("rw_async_ctl", {a_req_ready, a_req_done, a_req_err, a_m_valid, a_busy, a_grant_idx}, 32'd0);
    chk("rw_async_pay", {a_m_id, a_m_data}, 32'd0);
    tick();
    tick();
    rst_n = 1'b1;
    for (int k = 0; k < 4; k++) set_req(k, 7'h60 + 7'(k), 8'h70 + 8'(k));
    req_valid = 4'b1111;
    any_done  = 4'b0000;
    tick();
    chk("rw_first_mvalid", a_m_valid, 32'd1);
    chk("rw_first_grant", a_grant_idx, 32'd0);
    chk("rw_first_ready", a_req_ready, 32'h1);
    req_valid = 4'b0000;
    for (int c = 0; c < 20; c++) begin
      tick();
      any_done = any_done | a_req_done;
    end
    chk("rw_no_done", any_done, 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
